// File: rtl/div_rr_scheduler.sv
// Round-robin front end that shares one external sequential divider between N_REQ requesters.
// Grants, issues a start pulse, waits for done under a watchdog and returns a tagged response.
module div_rr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_a,
  input  logic [N_REQ*WIDTH-1:0] i_b,
  output logic [N_REQ-1:0]       o_ack,
  output logic                   o_busy,
  output logic                   o_div_start,
  output logic [WIDTH-1:0]       o_div_a,
  output logic [WIDTH-1:0]       o_div_b,
  input  logic                   i_div_done,
  input  logic                   i_div_dbz,
  input  logic                   i_div_ovf,
  input  logic [WIDTH-1:0]       i_div_val,
  output logic                   o_rsp_valid,
  output logic [IDW-1:0]         o_rsp_id,
  output logic [WIDTH-1:0]       o_rsp_val,
  output logic [1:0]             o_rsp_status
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     curId_q, curId_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   divA_q, divA_d;
  logic [WIDTH-1:0]   divB_q, divB_d;
  logic               rspValid_q, rspValid_d;
  logic [IDW-1:0]     rspId_q, rspId_d;
  logic [WIDTH-1:0]   rspVal_q, rspVal_d;
  logic [1:0]         rspStatus_q, rspStatus_d;

  logic               grantValid;
  logic [IDW-1:0]     grantIdx;
  logic [IDW-1:0]     ptrNext;

  // Descending offset scan so the last hit is the requester closest at/after the pointer.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[(int'(ptr_q) + i) % N_REQ]) begin
        grantValid = 1'b1;
        grantIdx   = IDW'((int'(ptr_q) + i) % N_REQ);
      end
    end
    ptrNext = (grantIdx == IDW'(N_REQ - 1)) ? '0 : grantIdx + IDW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      curId_q     <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      divA_q      <= '0;
      divB_q      <= '0;
      rspValid_q  <= 1'b0;
      rspId_q     <= '0;
      rspVal_q    <= '0;
      rspStatus_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      curId_q     <= curId_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      divA_q      <= divA_d;
      divB_q      <= divB_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspVal_q    <= rspVal_d;
      rspStatus_q <= rspStatus_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    curId_d     = curId_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    start_d     = 1'b0;
    divA_d      = divA_q;
    divB_d      = divB_q;
    rspValid_d  = 1'b0;
    rspId_d     = rspId_q;
    rspVal_d    = rspVal_q;
    rspStatus_d = rspStatus_q;

    case (state_q)
      ST_IDLE: begin
        if (grantValid) begin
          state_d = ST_ISSUE;
          ack_d   = N_REQ'(1) << grantIdx;
          start_d = 1'b1;
          divA_d  = i_a[int'(grantIdx)*WIDTH +: WIDTH];
          divB_d  = i_b[int'(grantIdx)*WIDTH +: WIDTH];
          curId_d = grantIdx;
          ptr_d   = ptrNext;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      // A done in the same cycle as the last watchdog count still returns the real result.
      ST_WAIT: begin
        if (i_div_done) begin
          state_d    = ST_RESP;
          rspValid_d = 1'b1;
          rspId_d    = curId_q;
          if (i_div_dbz) begin
            rspStatus_d = 2'b01;
            rspVal_d    = '0;
          end else if (i_div_ovf) begin
            rspStatus_d = 2'b10;
            rspVal_d    = '0;
          end else begin
            rspStatus_d = 2'b00;
            rspVal_d    = i_div_val;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          rspValid_d  = 1'b1;
          rspId_d     = curId_q;
          rspStatus_d = 2'b11;
          rspVal_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_ack        = ack_q;
  assign o_busy       = busy_q;
  assign o_div_start  = start_q;
  assign o_div_a      = divA_q;
  assign o_div_b      = divB_q;
  assign o_rsp_valid  = rspValid_q;
  assign o_rsp_id     = rspId_q;
  assign o_rsp_val    = rspVal_q;
  assign o_rsp_status = rspStatus_q;

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Scoreboard bench for div_rr_scheduler with a Q4.4 divider model and a round-robin reference model.
// Stimulus queues expected grants/responses; a monitor pops and compares whenever the DUT presents them.
module tb_div_rr_scheduler;

  localparam int WIDTH   = 8;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = 2;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*WIDTH-1:0] i_a;
  logic [N_REQ*WIDTH-1:0] i_b;
  logic [N_REQ-1:0]       o_ack;
  logic                   o_busy;
  logic                   o_div_start;
  logic [WIDTH-1:0]       o_div_a;
  logic [WIDTH-1:0]       o_div_b;
  logic                   i_div_done;
  logic                   i_div_dbz;
  logic                   i_div_ovf;
  logic [WIDTH-1:0]       i_div_val;
  logic                   o_rsp_valid;
  logic [IDW-1:0]         o_rsp_id;
  logic [WIDTH-1:0]       o_rsp_val;
  logic [1:0]             o_rsp_status;

  div_rr_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_a(i_a), .i_b(i_b),
    .o_ack(o_ack), .o_busy(o_busy), .o_div_start(o_div_start),
    .o_div_a(o_div_a), .o_div_b(o_div_b),
    .i_div_done(i_div_done), .i_div_dbz(i_div_dbz), .i_div_ovf(i_div_ovf), .i_div_val(i_div_val),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_val(o_rsp_val), .o_rsp_status(o_rsp_status)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         id;
    logic [7:0] val;
    logic [1:0] status;
    int         delay;
  } rsp_t;

  int         ackQ[$];
  rsp_t       rspQ[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         ackSeen = 0;
  int         rspSeen = 0;
  int         modelPtr = 0;
  int         divLat = 1;
  bit         divHang = 1'b0;
  int         injectReq = 0;
  logic [7:0] opA[N_REQ];
  logic [7:0] opB[N_REQ];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: first requesting index at or after the pointer, wrapping.
  function automatic int rrPick(input int ptr, input logic [N_REQ-1:0] mask);
    for (int i = 0; i < N_REQ; i++)
      if (mask[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
    return -1;
  endfunction

  // Reference: expected response from the requester's own operands (Q4.4 quotient).
  function automatic rsp_t refResponse(input int id, input logic [7:0] a, input logic [7:0] b,
                                       input int lat, input bit hang);
    rsp_t r;
    int   q;
    r.id = id;
    if (hang || lat > TIMEOUT) begin
      r.status = 2'b11;
      r.val    = 8'h00;
      r.delay  = 1 + TIMEOUT;
    end else begin
      r.delay = 1 + lat;
      if (b == 8'h00) begin
        r.status = 2'b01;
        r.val    = 8'h00;
      end else begin
        q = (int'(a) * 16) / int'(b);
        r.status = (q > 255) ? 2'b10 : 2'b00;
        r.val    = (q > 255) ? 8'h00 : q[7:0];
      end
    end
    return r;
  endfunction

  // Divider model: latches operands on start, answers divLat cycles later unless hung.
  initial begin
    bit          pending;
    int          cntDn;
    logic [15:0] quot;
    logic [7:0]  latA, latB;
    int          injectAck;
    pending = 1'b0; cntDn = 0; injectAck = 0; latA = '0; latB = '0; quot = '0;
    i_div_done = 1'b0; i_div_dbz = 1'b0; i_div_ovf = 1'b0; i_div_val = '0;
    forever begin
      @(negedge i_clk);
      i_div_done = 1'b0; i_div_dbz = 1'b0; i_div_ovf = 1'b0;
      if (injectAck != injectReq) begin
        injectAck  = injectReq;
        i_div_done = 1'b1;
        i_div_val  = 8'h55;
        pending    = 1'b0;
      end else if (i_rst) begin
        pending = 1'b0;
      end else if (pending) begin
        if (cntDn == 0) begin
          pending    = 1'b0;
          i_div_done = 1'b1;
          if (latB == 8'h00) begin
            i_div_dbz = 1'b1;
            i_div_ovf = 1'b1;
            i_div_val = 8'hA5;
          end else begin
            quot      = {4'h0, latA, 4'h0} / {8'h00, latB};
            i_div_ovf = (quot > 16'd255);
            i_div_val = quot[7:0];
          end
        end else begin
          cntDn--;
        end
      end else if (o_div_start && !divHang) begin
        pending = 1'b1;
        cntDn   = divLat - 1;
        latA    = o_div_a;
        latB    = o_div_b;
      end
    end
  end

  // Monitor: pops expected grants and responses as the DUT presents them.
  initial begin
    int   ackCyc;
    int   exp;
    int   lastId;
    bit   idleCheck;
    rsp_t r;
    ackCyc = 0; lastId = 0; idleCheck = 1'b0; exp = 0;
    forever begin
      @(negedge i_clk);
      if (idleCheck) begin
        idleCheck = 1'b0;
        checkOutput("busy_after_rsp", o_busy, 0);
        checkOutput("rsp_valid_one_cycle", o_rsp_valid, 0);
        checkOutput("rsp_id_hold", o_rsp_id, lastId);
      end
      if (o_ack != '0) begin
        checkOutput("start_with_ack", o_div_start, 1);
        checkOutput("busy_in_issue", o_busy, 1);
        if (ackQ.size() == 0) begin
          checkOutput("unexpected_ack", o_ack, 0);
        end else begin
          exp = ackQ.pop_front();
          checkOutput("ack_grant", o_ack, 32'(1) << exp);
        end
        ackCyc = cyc;
        ackSeen++;
      end else if (o_div_start) begin
        checkOutput("start_without_ack", o_div_start, 0);
      end
      if (o_rsp_valid) begin
        if (rspQ.size() == 0) begin
          checkOutput("unexpected_rsp", o_rsp_valid, 0);
        end else begin
          r = rspQ.pop_front();
          checkOutput("rsp_id", o_rsp_id, r.id);
          checkOutput("rsp_val", o_rsp_val, r.val);
          checkOutput("rsp_status", o_rsp_status, r.status);
          checkOutput("rsp_latency", cyc - ackCyc, r.delay);
          lastId    = r.id;
          idleCheck = 1'b1;
        end
        rspSeen++;
      end
    end
  end

  task automatic driveOperands();
    for (int k = 0; k < N_REQ; k++) begin
      i_a[k*WIDTH +: WIDTH] = opA[k];
      i_b[k*WIDTH +: WIDTH] = opB[k];
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] mask, input int nTx, input int lat, input bit hang);
    int targetAck;
    int targetRsp;
    int guard;
    int w;
    targetAck = ackSeen + nTx;
    targetRsp = rspSeen + nTx;
    driveOperands();
    divLat  = lat;
    divHang = hang;
    for (int t = 0; t < nTx; t++) begin
      w = rrPick(modelPtr, mask);
      ackQ.push_back(w);
      rspQ.push_back(refResponse(w, opA[w], opB[w], lat, hang));
      modelPtr = (w + 1) % N_REQ;
    end
    i_req = mask;
    guard = 0;
    while (ackSeen < targetAck && guard < 2000) begin
      @(posedge i_clk);
      guard++;
    end
    #1 i_req = '0;
    while (rspSeen < targetRsp && guard < 4000) begin
      @(posedge i_clk);
      guard++;
    end
    checkOutput("rsp_count", rspSeen, targetRsp);
    repeat (2) @(negedge i_clk);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_ack", o_ack, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_start", o_div_start, 0);
    checkOutput("rst_div_a", o_div_a, 0);
    checkOutput("rst_div_b", o_div_b, 0);
    checkOutput("rst_rsp_valid", o_rsp_valid, 0);
    checkOutput("rst_rsp_id", o_rsp_id, 0);
    checkOutput("rst_rsp_val", o_rsp_val, 0);
    checkOutput("rst_rsp_status", o_rsp_status, 0);
  endtask

  task automatic pulseReset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    modelPtr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    int guard;
    i_rst = 1'b1;
    i_req = '0;
    i_a   = '0;
    i_b   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      opA[k] = 8'h10;
      opB[k] = 8'h08;
    end
    repeat (3) @(negedge i_clk);
    checkResetOutputs();
    i_rst = 1'b0;
    @(negedge i_clk);

    $display("[TB] directed: ok, dbz, ovf");
    opA[1] = 8'h30; opB[1] = 8'h20;
    applyStimulus(4'b0010, 1, 3, 1'b0);
    opA[2] = 8'h40; opB[2] = 8'h00;
    applyStimulus(4'b0100, 1, 2, 1'b0);
    opA[0] = 8'hF0; opB[0] = 8'h01;
    applyStimulus(4'b0001, 1, 4, 1'b0);

    $display("[TB] fairness from reset");
    pulseReset();
    for (int k = 0; k < N_REQ; k++) begin
      opA[k] = 8'($urandom_range(0, 255));
      opB[k] = 8'($urandom_range(1, 255));
    end
    applyStimulus(4'b1111, 8, 2, 1'b0);
    applyStimulus(4'b1010, 4, 1, 1'b0);

    $display("[TB] watchdog");
    applyStimulus(4'b1000, 1, 1, 1'b1);
    applyStimulus(4'b0001, 1, 3, 1'b0);
    applyStimulus(4'b0100, 1, TIMEOUT, 1'b0);
    applyStimulus(4'b0010, 1, TIMEOUT + 1, 1'b0);
    applyStimulus(4'b0010, 1, 2, 1'b0);

    $display("[TB] reset during wait");
    opA[2] = 8'h20; opB[2] = 8'h10;
    driveOperands();
    divLat  = 20;
    divHang = 1'b0;
    ackQ.push_back(rrPick(modelPtr, 4'b0100));
    i_req = 4'b0100;
    guard = 0;
    while (ackQ.size() != 0 && guard < 200) begin
      @(posedge i_clk);
      guard++;
    end
    #1 i_req = '0;
    repeat (3) @(posedge i_clk);
    pulseReset();
    checkResetOutputs();
    injectReq++;
    repeat (4) @(negedge i_clk);
    checkOutput("idle_after_late_done", o_busy, 0);
    opA[1] = 8'h50; opB[1] = 8'h28;
    opA[3] = 8'h11; opB[3] = 8'h22;
    applyStimulus(4'b1010, 1, 2, 1'b0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < N_REQ; k++) begin
        opA[k] = 8'($urandom_range(0, 255));
        opB[k] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      applyStimulus(4'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(1, 8), 1'b0);
    end

    checkOutput("ack_queue_drained", ackQ.size(), 0);
    checkOutput("rsp_queue_drained", rspQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
